// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: producer/consumer bundle for stream_mux_rr; xfer_count exists only with STREAM_MUX_STATS_EN.
interface stream_mux_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int CHW = (N_CH > 2) ? $clog2(N_CH) : 1;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [CHW-1:0]        out_chan;
    logic                  out_valid;
    logic                  out_ready;
`ifdef STREAM_MUX_STATS_EN
    logic [15:0]           xfer_count;
`endif
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
`ifdef STREAM_MUX_STATS_EN
        , output xfer_count
`endif
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
`ifdef STREAM_MUX_STATS_EN
        , input xfer_count
`endif
    );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready mux with one output register, fixed-priority or round-robin.
// Defining STREAM_MUX_STATS_EN adds a 16-bit wrapping output-transfer counter (xfer_count).
module stream_mux_rr #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 8,
    parameter int ROUND_ROBIN = 1
) (
    input logic clk,
    input logic rst,
    stream_mux_rr_if.slave bus
);
    localparam int CHW = (N_CH > 2) ? $clog2(N_CH) : 1;
    localparam logic [CHW-1:0] LAST = CHW'(N_CH - 1);
    logic [CHW-1:0]   ptr_q, ptr_d, chan_q, chan_d, sel, idx;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, any, slot_free, take;
    // Scan from the farthest candidate down so the one nearest ptr wins.
    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = CHW'((int'(ptr_q) + k) % N_CH);
            if (bus.in_valid[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end
    assign slot_free    = !valid_q || bus.out_ready;
    assign take         = slot_free && any;
    assign bus.in_ready = take ? (N_CH'(1) << sel) : '0;
    always_comb begin
        data_d  = take ? bus.in_data[int'(sel)*WIDTH +: WIDTH] : data_q;
        chan_d  = take ? sel : chan_q;
        valid_d = take || (valid_q && !bus.out_ready);
        ptr_d   = (ROUND_ROBIN != 0 && take) ? ((sel == LAST) ? '0 : sel + 1'b1) : ptr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = valid_q;
`ifdef STREAM_MUX_STATS_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= (valid_q && bus.out_ready) ? cnt_q + 16'd1 : cnt_q;
    end
    assign bus.xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench driving a round-robin and a fixed-priority mux with the same stimulus.
module tb_stream_mux_rr;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic           out_ready;
    int n_cmp = 0;
    int n_err = 0;
    int m_ptr [2];
    logic [CW+W-1:0] q0 [$];
    logic [CW+W-1:0] q1 [$];
    logic [N-1:0]  o_rdy [2];
    logic          o_vld [2];
    logic [W-1:0]  o_dat [2];
    logic [CW-1:0] o_ch  [2];

    always #5 clk = ~clk;

    stream_mux_rr_if #(.N_CH(N), .WIDTH(W)) rr_if ();
    stream_mux_rr_if #(.N_CH(N), .WIDTH(W)) fp_if ();
    stream_mux_rr #(.N_CH(N), .WIDTH(W), .ROUND_ROBIN(1)) u_rr (.clk(clk), .rst(rst), .bus(rr_if));
    stream_mux_rr #(.N_CH(N), .WIDTH(W), .ROUND_ROBIN(0)) u_fp (.clk(clk), .rst(rst), .bus(fp_if));

    assign rr_if.in_data   = in_data;
    assign rr_if.in_valid  = in_valid;
    assign rr_if.out_ready = out_ready;
    assign fp_if.in_data   = in_data;
    assign fp_if.in_valid  = in_valid;
    assign fp_if.out_ready = out_ready;
    assign o_rdy[0] = rr_if.in_ready;
    assign o_rdy[1] = fp_if.in_ready;
    assign o_vld[0] = rr_if.out_valid;
    assign o_vld[1] = fp_if.out_valid;
    assign o_dat[0] = rr_if.out_data;
    assign o_dat[1] = fp_if.out_data;
    assign o_ch[0]  = rr_if.out_chan;
    assign o_ch[1]  = fp_if.out_chan;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gnt(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // One cycle: check outputs against the scoreboard head, then update the model at the edge.
    task automatic step(input string tag);
        int sz [2];
        int g [2];
        logic fr [2];
        logic [CW+W-1:0] hd;
        logic [N-1:0] er;
        string nm;
        #1;
        for (int d = 0; d < 2; d++) begin
            nm = (d == 0) ? "rr" : "fp";
            sz[d] = (d == 0) ? q0.size() : q1.size();
            hd = '0;
            if (sz[d] != 0) hd = (d == 0) ? q0[0] : q1[0];
            chk($sformatf("%s/%s/out_valid", nm, tag), 64'(o_vld[d]), 64'(sz[d] != 0));
            if (sz[d] != 0) begin
                chk($sformatf("%s/%s/out_data", nm, tag), 64'(o_dat[d]), 64'(hd[W-1:0]));
                chk($sformatf("%s/%s/out_chan", nm, tag), 64'(o_ch[d]), 64'(hd[CW+W-1:W]));
            end
            fr[d] = (sz[d] == 0) || out_ready;
            g[d] = gnt(in_valid, m_ptr[d]);
            er = (fr[d] && g[d] >= 0) ? (N'(1) << g[d]) : '0;
            chk($sformatf("%s/%s/in_ready", nm, tag), 64'(o_rdy[d]), 64'(er));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (sz[d] != 0 && out_ready) begin
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
            if (fr[d] && g[d] >= 0) begin
                if (d == 0) q0.push_back({CW'(g[d]), in_data[g[d]*W +: W]});
                else        q1.push_back({CW'(g[d]), in_data[g[d]*W +: W]});
                if (d == 0) m_ptr[0] = (g[d] + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    // Reset lands mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s/rst/out_valid", tag), 64'(o_vld[d]), 64'd0);
            chk($sformatf("%s/rst/out_data", tag), 64'(o_dat[d]), 64'd0);
            chk($sformatf("%s/rst/out_chan", tag), 64'(o_ch[d]), 64'd0);
        end
`ifdef STREAM_MUX_STATS_EN
        chk($sformatf("%s/rst/xfer_count_rr", tag), 64'(rr_if.xfer_count), 64'd0);
        chk($sformatf("%s/rst/xfer_count_fp", tag), 64'(fp_if.xfer_count), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        m_ptr[0] = 0;
        m_ptr[1] = 0;
    endtask

    initial begin
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        m_ptr[0]  = 0;
        m_ptr[1]  = 0;
        #1 rst = 1'b1;
        @(negedge clk);
        do_reset("init");
        // Fixed-priority pattern; the RR instance alternates on the same inputs.
        in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step("prio");
        in_valid = '0;
        for (int i = 0; i < 2; i++) step("drain");
        do_reset("pre_rr");
        in_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) step("rr_all");
        in_valid = '0;
        step("rr_tail");
        do_reset("pre_bp");
        // Backpressure: ch2 word held while others request.
        in_data   = {8'h3C, 8'hA5, 8'h1C, 8'h0C};
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        step("bp_load");
        in_valid = 4'b1011;
        for (int i = 0; i < 3; i++) step("bp_stall");
        in_valid  = '0;
        out_ready = 1'b1;
        step("bp_release");
        step("bp_empty");
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        step("mid_load");
        in_valid = '0;
        do_reset("mid_op");
        // Wrap: grant ch2 leaves ptr at 3, then ch3 beats ch0.
        in_data   = {8'h93, 8'h92, 8'h91, 8'h90};
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        step("wrap_ch2");
        in_valid = 4'b1001;
        step("wrap_a");
        step("wrap_b");
        in_valid = '0;
        step("wrap_c");
        step("wrap_d");
`ifdef STREAM_MUX_STATS_EN
        do_reset("pre_stats");
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        repeat (65538) @(negedge clk);
        in_valid  = '0;
        out_ready = 1'b0;
        #1;
        chk("stats/xfer_count_rr", 64'(rr_if.xfer_count), 64'd1);
        chk("stats/xfer_count_fp", 64'(fp_if.xfer_count), 64'd1);
        do_reset("post_stats");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, registered successor to the single-bit combinational 2:1 mux.
- Selects one of N_CH valid/ready input streams of WIDTH bits and forwards it through a single output register stage.
- Selection is either fixed-priority or round-robin.
- Sits between multiple producers and one shared consumer, e.g. a bus or UART TX path.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel (1..64).
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = fixed priority with the lowest index winning.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready, combinational.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  CHW  registered index of the source channel; CHW = max(1, clog2(N_CH)).
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- xfer_count  output  16  present only with STREAM_MUX_STATS_EN.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer=0.
  - xfer_count=0.
- Transfer rules:
  - Input transfer on channel i: in_valid[i] && in_ready[i] at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- slot_free = !out_valid || out_ready, combinational. Output is full throughput, one word per cycle.
- Grant:
  - Computed combinationally from in_valid and the priority pointer (pointer fixed at 0 when ROUND_ROBIN=0).
  - Winner = first set in_valid scanning ptr, ptr+1, ..., wrapping modulo N_CH.
- in_ready[i] = slot_free && grant[i]:
  - At most one bit is set.
  - in_ready is 0 for every channel whose in_valid is low.
- On an input transfer from channel i, at the next edge:
  - out_data <= channel i data.
  - out_chan <= i.
  - out_valid <= 1.
  - If ROUND_ROBIN, ptr <= (i+1) mod N_CH.
- Output transfer with no input transfer in the same edge: out_valid <= 0. out_data and out_chan hold their values.
- Simultaneous output and input transfer: the register is replaced with the new word and out_valid stays 1 (no bubble).
- No valid inputs: ptr unchanged, no grant issued.
- Latency: input transfer at edge k, word visible on out_* after edge k.
- Output stability: while out_valid && !out_ready, out_data and out_chan are stable and all in_ready are 0.
- ptr wrap: granting channel N_CH-1 sets ptr to 0.
- Reset asserted mid-operation: any held word is dropped immediately (out_valid falls asynchronously). No partial state survives.
- Producer contract: no combinational path from in_ready back to in_valid is required. Producers must not drop in_valid before their transfer completes.

Optional Feature:
- Macro STREAM_MUX_STATS_EN.
- Defined:
  - Port xfer_count exists.
  - 16-bit counter incremented on every output transfer.
  - Wraps 0xFFFF -> 0x0000.
  - Reset to 0.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately, without waiting for a clock edge.
- Fixed priority (ROUND_ROBIN=0, N_CH=4): in_valid=4'b1010, data ch1=0x11, ch3=0x33, out_ready=1 -> sequence out_chan 1,1,1... with 0x11 each cycle. in_ready=4'b0010 every cycle.
- Round-robin (N_CH=4), all in_valid=1, out_ready=1:
  - Grants 0,1,2,3,0 on consecutive cycles.
  - out_valid held 1 continuously with no bubbles.
- Backpressure:
  - Ch2 sends 0xA5 while out_ready=0 for 3 cycles -> out_data=0xA5 and out_chan=2 stable, in_ready=0 for all channels.
  - Then out_ready=1 for one cycle -> single output transfer.
- Wrap: ptr=3 after granting ch2; only ch0 and ch3 valid -> ch3 granted first, then ptr=0 and ch0 granted next.
- STATS (STREAM_MUX_STATS_EN defined): 65537 output transfers -> xfer_count=1. Reset -> xfer_count=0.
